// File: rtl/end_screen_overlay.sv
// End-screen overlay: once the game is over, reveals the GAME OVER banner and each player's
// score row one glyph at a time, then blinks a trophy beside every top-scoring player.
// Outputs are registered; ending_idx/ending_read_address select a pixel in the glyph ROM.
module end_screen_overlay #(
  parameter int unsigned N_PLAYERS     = 2,
  parameter int unsigned N_DIGITS      = 4,
  parameter int unsigned CHAR_W        = 30,
  parameter int unsigned CHAR_H        = 45,
  parameter int unsigned REVEAL_FRAMES = 8,
  parameter int unsigned BLINK_FRAMES  = 30
) (
  input  logic                            Clk,
  input  logic                            Reset,
  input  logic                            frame_start,
  input  logic [9:0]                      DrawX,
  input  logic [9:0]                      DrawY,
  input  logic [1:0]                      game_state,
  input  logic [4*N_DIGITS*N_PLAYERS-1:0] scores,
  output logic                            is_ending,
  output logic [4:0]                      ending_idx,
  output logic [18:0]                     ending_read_address,
  output logic                            reveal_done
);

  localparam int unsigned ROW_LEN = 3 + N_DIGITS;
  localparam int unsigned N_GLYPH = 8 + N_PLAYERS * ROW_LEN;
  localparam int unsigned SCORE_W = 4 * N_DIGITS;
  localparam int unsigned ALL_W   = SCORE_W * N_PLAYERS;
  localparam int unsigned CNT_W   = $clog2(N_GLYPH + 1);
  localparam int unsigned FRM_W   = $clog2(REVEAL_FRAMES + 1);
  localparam int unsigned BLK_W   = $clog2(BLINK_FRAMES + 1);

  localparam logic [CNT_W-1:0] GLYPH_ALL = CNT_W'(N_GLYPH);
  localparam logic [FRM_W-1:0] FRM_LAST  = FRM_W'(REVEAL_FRAMES - 1);
  localparam logic [BLK_W-1:0] BLK_LAST  = BLK_W'(BLINK_FRAMES - 1);

  typedef enum logic [1:0] {StIdle, StReveal, StHold} state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   reveal_cnt_q, reveal_cnt_d;
  logic [FRM_W-1:0]   frame_cnt_q, frame_cnt_d;
  logic [BLK_W-1:0]   blink_cnt_q, blink_cnt_d;
  logic               phase_q, phase_d;
  logic [ALL_W-1:0]   scores_q, scores_d;
  logic [ALL_W-1:0]   clamped;
  logic [SCORE_W-1:0] max_score;
  logic [N_PLAYERS-1:0] winner;
  logic               game_over;
  logic               show;
  logic               trophy_on;
  logic               hit_d;
  logic [4:0]         idx_d;
  logic [18:0]        addr_d;

  assign game_over = (game_state == 2'b10);
  // Exit wins over display: the overlay drops on the same edge that leaves game-over.
  assign show      = (state_q != StIdle) && game_over;
  assign trophy_on = (state_q == StHold) && phase_q;
  assign reveal_done = (state_q == StHold);

  // True when the pixel falls inside the glyph box at (gx, gy); signed maths avoids wrap hits.
  function automatic logic in_box(input logic [9:0] px, input logic [9:0] py,
                                  input int gx, input int gy);
    int dx;
    int dy;
    dx = int'({22'd0, px}) - gx;
    dy = int'({22'd0, py}) - gy;
    return (dx >= 0) && (dx < int'(CHAR_W)) && (dy >= 0) && (dy < int'(CHAR_H));
  endfunction

  // Offset of the pixel within the glyph at (gx, gy); only meaningful on a hit.
  function automatic logic [18:0] box_addr(input logic [9:0] px, input logic [9:0] py,
                                           input int gx, input int gy);
    int dx;
    int dy;
    dx = int'({22'd0, px}) - gx;
    dy = int'({22'd0, py}) - gy;
    return 19'(dx + dy * int'(CHAR_W));
  endfunction

  // Clamp every BCD digit above 9 down to 9 before it is latched.
  always_comb begin
    clamped = '0;
    for (int d = 0; d < int'(N_PLAYERS * N_DIGITS); d++) begin
      clamped[4*d +: 4] = (scores[4*d +: 4] > 4'd9) ? 4'd9 : scores[4*d +: 4];
    end
  end

  // Winner set: clamped BCD of equal length compares like the number it encodes.
  always_comb begin
    max_score = '0;
    winner    = '0;
    for (int p = 0; p < int'(N_PLAYERS); p++) begin
      if (scores_q[SCORE_W*p +: SCORE_W] > max_score) max_score = scores_q[SCORE_W*p +: SCORE_W];
    end
    for (int p = 0; p < int'(N_PLAYERS); p++) begin
      winner[p] = (scores_q[SCORE_W*p +: SCORE_W] == max_score);
    end
  end

  // Next-state logic for the reveal/hold sequence and its frame counters.
  always_comb begin
    state_d      = state_q;
    reveal_cnt_d = reveal_cnt_q;
    frame_cnt_d  = frame_cnt_q;
    blink_cnt_d  = blink_cnt_q;
    phase_d      = phase_q;
    scores_d     = scores_q;
    unique case (state_q)
      StIdle: begin
        if (game_over) begin
          state_d      = StReveal;
          reveal_cnt_d = '0;
          frame_cnt_d  = '0;
          scores_d     = clamped;
        end
      end
      StReveal: begin
        if (!game_over) begin
          state_d = StIdle;
        end else if (reveal_cnt_q == GLYPH_ALL) begin
          state_d     = StHold;
          phase_d     = 1'b1;
          blink_cnt_d = '0;
        end else if (frame_start) begin
          if (frame_cnt_q == FRM_LAST) begin
            frame_cnt_d  = '0;
            reveal_cnt_d = reveal_cnt_q + 1'b1;
          end else begin
            frame_cnt_d = frame_cnt_q + 1'b1;
          end
        end
      end
      StHold: begin
        if (!game_over) begin
          state_d = StIdle;
        end else if (frame_start) begin
          if (blink_cnt_q == BLK_LAST) begin
            blink_cnt_d = '0;
            phase_d     = ~phase_q;
          end else begin
            blink_cnt_d = blink_cnt_q + 1'b1;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State, counters and latched scores.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q      <= StIdle;
      reveal_cnt_q <= '0;
      frame_cnt_q  <= '0;
      blink_cnt_q  <= '0;
      phase_q      <= 1'b0;
      scores_q     <= '0;
    end else begin
      state_q      <= state_d;
      reveal_cnt_q <= reveal_cnt_d;
      frame_cnt_q  <= frame_cnt_d;
      blink_cnt_q  <= blink_cnt_d;
      phase_q      <= phase_d;
      scores_q     <= scores_d;
    end
  end

  // Hit test over all glyphs in reveal order; first hit wins, trophies checked last.
  always_comb begin
    int gx;
    int gy;
    int gi;
    int p;
    int s;
    int shown;
    hit_d  = 1'b0;
    idx_d  = '0;
    addr_d = '0;
    gx     = 0;
    gy     = 0;
    gi     = 0;
    p      = 0;
    s      = 0;
    shown  = int'(reveal_cnt_q);
    if (show) begin
      for (int k = 0; k < int'(N_GLYPH); k++) begin
        if (k < 4) begin
          gx = 185 + 30 * k;
          gy = 165;
          gi = 10 + k;
        end else if (k < 8) begin
          gx = 335 + 30 * (k - 4);
          gy = 165;
          gi = 14 + (k - 4);
        end else begin
          p  = (k - 8) / int'(ROW_LEN);
          s  = (k - 8) % int'(ROW_LEN);
          gy = 270 + 75 * p;
          if (s == 0) begin
            gx = 185;
            gi = 18;
          end else if (s == 1) begin
            gx = 215;
            gi = p + 1;
          end else if (s == 2) begin
            gx = 260;
            gi = 24;
          end else begin
            gx = 300 + 30 * (s - 3);
            gi = int'(scores_q[SCORE_W*p + 4*(int'(N_DIGITS) - 1 - (s - 3)) +: 4]);
          end
        end
        if (!hit_d && (k < shown) && in_box(DrawX, DrawY, gx, gy)) begin
          hit_d  = 1'b1;
          idx_d  = 5'(gi);
          addr_d = box_addr(DrawX, DrawY, gx, gy);
        end
      end
      for (int t = 0; t < int'(N_PLAYERS); t++) begin
        gx = 300 + 30 * int'(N_DIGITS);
        gy = 270 + 75 * t;
        if (!hit_d && trophy_on && winner[t] && in_box(DrawX, DrawY, gx, gy)) begin
          hit_d  = 1'b1;
          idx_d  = 5'd22;
          addr_d = box_addr(DrawX, DrawY, gx, gy);
        end
      end
    end
  end

  // Registered pixel outputs.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      is_ending           <= 1'b0;
      ending_idx          <= '0;
      ending_read_address <= '0;
    end else begin
      is_ending           <= hit_d;
      ending_idx          <= idx_d;
      ending_read_address <= addr_d;
    end
  end

endmodule

// File: tb/tb_end_screen_overlay.sv
// Self-checking bench for end_screen_overlay: stimulus pushes expected pixels into a queue,
// a negedge monitor pops and compares against the registered outputs.
module tb_end_screen_overlay;
  localparam int NP = 2;
  localparam int ND = 4;
  localparam int CW = 30;
  localparam int CH = 45;
  localparam int RF = 1;
  localparam int BF = 2;
  localparam int G  = 8 + NP * (3 + ND);

  logic              Clk = 1'b0;
  logic              Reset;
  logic              frame_start;
  logic [9:0]        DrawX;
  logic [9:0]        DrawY;
  logic [1:0]        game_state;
  logic [4*ND*NP-1:0] scores;
  logic              is_ending;
  logic [4:0]        ending_idx;
  logic [18:0]       ending_read_address;
  logic              reveal_done;

  end_screen_overlay #(
    .N_PLAYERS(NP), .N_DIGITS(ND), .CHAR_W(CW), .CHAR_H(CH),
    .REVEAL_FRAMES(RF), .BLINK_FRAMES(BF)
  ) dut (
    .Clk(Clk), .Reset(Reset), .frame_start(frame_start), .DrawX(DrawX), .DrawY(DrawY),
    .game_state(game_state), .scores(scores), .is_ending(is_ending), .ending_idx(ending_idx),
    .ending_read_address(ending_read_address), .reveal_done(reveal_done)
  );

  always #5 Clk = ~Clk;

  typedef struct {
    logic e;
    int   idx;
    int   addr;
    logic done;
    int   px;
    int   py;
  } exp_t;

  exp_t q[$];
  int n_checks = 0;
  int n_pass   = 0;

  // Reference model: abstract game progress counted in frame pulses.
  bit m_active = 0;
  bit m_hold   = 0;
  int m_pulses = 0;
  int m_hpulses = 0;
  int gx_t [G];
  int gy_t [G];
  int gi_t [G];
  bit m_win [NP];

  task automatic check(input string name, input int act, input int expv);
    n_checks++;
    if (act == expv) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, expv);
  endtask

  function automatic void latch_scores();
    int val [NP];
    int mx;
    int d;
    logic [3:0] nib;
    mx = -1;
    for (int p = 0; p < NP; p++) begin
      val[p] = 0;
      gx_t[8 + p*(3+ND)] = 185; gy_t[8 + p*(3+ND)] = 270 + 75*p; gi_t[8 + p*(3+ND)] = 18;
      gx_t[9 + p*(3+ND)] = 215; gy_t[9 + p*(3+ND)] = 270 + 75*p; gi_t[9 + p*(3+ND)] = p + 1;
      gx_t[10 + p*(3+ND)] = 260; gy_t[10 + p*(3+ND)] = 270 + 75*p; gi_t[10 + p*(3+ND)] = 24;
      for (int j = 0; j < ND; j++) begin
        nib = scores[4*ND*p + 4*(ND-1-j) +: 4];
        d = (nib > 4'd9) ? 9 : int'(nib);
        val[p] = val[p] * 10 + d;
        gx_t[11 + p*(3+ND) + j] = 300 + 30*j;
        gy_t[11 + p*(3+ND) + j] = 270 + 75*p;
        gi_t[11 + p*(3+ND) + j] = d;
      end
      if (val[p] > mx) mx = val[p];
    end
    for (int p = 0; p < NP; p++) m_win[p] = (val[p] == mx);
    for (int i = 0; i < 4; i++) begin
      gx_t[i] = 185 + 30*i;     gy_t[i] = 165;     gi_t[i] = 10 + i;
      gx_t[4+i] = 335 + 30*i;   gy_t[4+i] = 165;   gi_t[4+i] = 14 + i;
    end
  endfunction

  function automatic void model_step(input logic [1:0] gs, input logic fs);
    if (gs != 2'b10) begin
      m_active = 0;
      m_hold   = 0;
    end else if (!m_active) begin
      m_active = 1;
      m_hold   = 0;
      m_pulses = 0;
      latch_scores();
    end else if (!m_hold) begin
      if (m_pulses / RF >= G) begin
        m_hold    = 1;
        m_hpulses = 0;
      end else if (fs) begin
        m_pulses++;
      end
    end else if (fs) begin
      m_hpulses++;
    end
  endfunction

  function automatic bit inside_box(input int x, input int y, input int gx, input int gy);
    return (x >= gx) && (x < gx + CW) && (y >= gy) && (y < gy + CH);
  endfunction

  function automatic void exp_pixel(input int x, input int y, input logic [1:0] gs,
                                    output logic e, output int idx, output int addr);
    int rev;
    bit found;
    e = 0; idx = 0; addr = 0; found = 0;
    rev = m_pulses / RF;
    if (rev > G) rev = G;
    if (m_active && gs == 2'b10) begin
      for (int k = 0; k < rev; k++) begin
        if (!found && inside_box(x, y, gx_t[k], gy_t[k])) begin
          found = 1; e = 1; idx = gi_t[k];
          addr = (x - gx_t[k]) + (y - gy_t[k]) * CW;
        end
      end
      if (!found && m_hold && ((m_hpulses / BF) % 2 == 0)) begin
        for (int p = 0; p < NP; p++) begin
          if (!found && m_win[p] && inside_box(x, y, 300 + 30*ND, 270 + 75*p)) begin
            found = 1; e = 1; idx = 22;
            addr = (x - (300 + 30*ND)) + (y - (270 + 75*p)) * CW;
          end
        end
      end
    end
  endfunction

  task automatic tick(input logic [1:0] gs, input logic fs, input int x, input int y);
    exp_t r;
    logic e;
    int ei;
    int ea;
    game_state = gs; frame_start = fs; DrawX = x[9:0]; DrawY = y[9:0];
    exp_pixel(x, y, gs, e, ei, ea);
    @(posedge Clk);
    model_step(gs, fs);
    r.e = e; r.idx = ei; r.addr = ea; r.done = m_hold; r.px = x; r.py = y;
    q.push_back(r);
    #1;
    frame_start = 1'b0;
  endtask

  function automatic logic [31:0] rand_scores();
    logic [31:0] s;
    for (int i = 0; i < 8; i++) begin
      s[4*i +: 4] = ($urandom_range(0, 4) == 0) ? 4'($urandom_range(10, 15))
                                                : 4'($urandom_range(0, 9));
    end
    if ($urandom_range(0, 3) == 0) s[31:16] = s[15:0];
    return s;
  endfunction

  task automatic run_to_hold(input logic [31:0] s);
    tick(2'b00, 1'b0, 0, 0);
    scores = s;
    tick(2'b10, 1'b0, 0, 0);
    for (int i = 0; i < G * RF; i++) tick(2'b10, 1'b1, $urandom_range(170, 470), 300);
    tick(2'b10, 1'b0, 0, 0);
  endtask

  task automatic async_reset();
    @(negedge Clk);
    #1 Reset = 1'b1;
    #1;
    check("areset_is_ending", int'(is_ending), 0);
    check("areset_idx", int'(ending_idx), 0);
    check("areset_addr", int'(ending_read_address), 0);
    check("areset_done", int'(reveal_done), 0);
    m_active = 0; m_hold = 0;
    @(posedge Clk);
    #1 Reset = 1'b0;
  endtask

  // Monitor: outputs are registered, so each pushed expectation is due at the next negedge.
  always @(negedge Clk) begin
    exp_t r;
    if (q.size() > 0) begin
      r = q.pop_front();
      n_checks++;
      if (is_ending === r.e && int'(ending_idx) == r.idx &&
          int'(ending_read_address) == r.addr && reveal_done === r.done) begin
        n_pass++;
      end else begin
        $display("FAIL pixel (%0d,%0d) t=%0t: got e=%0b idx=%0d addr=%0d done=%0b expected e=%0b idx=%0d addr=%0d done=%0b",
                 r.px, r.py, $time, is_ending, ending_idx, ending_read_address, reveal_done,
                 r.e, r.idx, r.addr, r.done);
      end
    end
  end

  initial begin
    Reset = 1'b1; frame_start = 1'b0; DrawX = '0; DrawY = '0; game_state = 2'b00; scores = '0;
    #1;
    check("reset_is_ending", int'(is_ending), 0);
    check("reset_idx", int'(ending_idx), 0);
    check("reset_done", int'(reveal_done), 0);
    repeat (3) @(posedge Clk);
    #1 Reset = 1'b0;

    // First glyph appears one pulse after entry.
    scores = {16'h0456, 16'h0123};
    repeat (2) tick(2'b00, 1'b0, 190, 170);
    tick(2'b10, 1'b0, 190, 170);
    tick(2'b10, 1'b0, 190, 170);
    @(negedge Clk) check("no_pulse_hidden", int'(is_ending), 0);
    tick(2'b10, 1'b1, 190, 170);
    tick(2'b10, 1'b0, 190, 170);
    @(negedge Clk);
    check("first_glyph_on", int'(is_ending), 1);
    check("first_glyph_idx", int'(ending_idx), 10);
    check("first_glyph_addr", int'(ending_read_address), 155);

    // Remaining 21 pulses, then HOLD with the trophy on the higher score only.
    for (int i = 0; i < 21; i++) tick(2'b10, 1'b1, $urandom_range(170, 470), $urandom_range(160, 430));
    tick(2'b10, 1'b0, 425, 350);
    tick(2'b10, 1'b0, 425, 350);
    @(negedge Clk);
    check("hold_done", int'(reveal_done), 1);
    check("trophy_p2_idx", int'(ending_idx), 22);
    tick(2'b10, 1'b0, 425, 275);
    @(negedge Clk) check("trophy_p1_off", int'(is_ending), 0);
    tick(2'b10, 1'b1, 425, 350);
    tick(2'b10, 1'b1, 425, 350);
    tick(2'b10, 1'b0, 425, 350);
    @(negedge Clk) check("trophy_blink_off", int'(is_ending), 0);

    // Glyph boundaries.
    tick(2'b10, 1'b0, 215, 170);
    @(negedge Clk) check("edge_next_glyph", int'(ending_idx), 11);
    tick(2'b10, 1'b0, 215, 210);
    @(negedge Clk) check("edge_below", int'(is_ending), 0);

    // Tie: both trophies.
    run_to_hold({16'h0500, 16'h0500});
    tick(2'b10, 1'b0, 425, 275);
    @(negedge Clk) check("tie_p1_trophy", int'(ending_idx), 22);
    tick(2'b10, 1'b0, 425, 350);
    @(negedge Clk) check("tie_p2_trophy", int'(ending_idx), 22);

    // Out-of-range digit clamps to 9 for display and ranking.
    run_to_hold({16'h0950, 16'h0C00});
    tick(2'b10, 1'b0, 335, 275);
    @(negedge Clk) check("clamp_digit", int'(ending_idx), 9);
    tick(2'b10, 1'b0, 425, 350);
    @(negedge Clk) check("clamp_rank_p2", int'(ending_idx), 22);

    // Exit mid-reveal, then re-entry restarts from nothing shown.
    tick(2'b00, 1'b0, 0, 0);
    tick(2'b10, 1'b0, 190, 170);
    for (int i = 0; i < 5; i++) tick(2'b10, 1'b1, 190, 170);
    tick(2'b00, 1'b1, 190, 170);
    @(negedge Clk);
    check("exit_hidden", int'(is_ending), 0);
    check("exit_not_done", int'(reveal_done), 0);
    tick(2'b10, 1'b0, 190, 170);
    tick(2'b10, 1'b0, 190, 170);
    @(negedge Clk) check("reentry_restart", int'(is_ending), 0);

    // Randomized games with score churn, exits and asynchronous resets.
    for (int r = 0; r < 10; r++) begin
      scores = rand_scores();
      for (int c = 0; c < 150; c++) begin
        scores = rand_scores();
        if ($urandom_range(0, 119) == 0) begin
          tick(2'b00, 1'($urandom_range(0, 1)), $urandom_range(170, 470), $urandom_range(160, 430));
        end else if ($urandom_range(0, 199) == 0) begin
          async_reset();
        end else if ($urandom_range(0, 9) == 0) begin
          tick(2'b10, 1'($urandom_range(0, 2) == 0), $urandom_range(0, 1023), $urandom_range(0, 1023));
        end else begin
          tick(2'b10, 1'($urandom_range(0, 2) == 0), $urandom_range(170, 470), $urandom_range(160, 430));
        end
      end
      tick(2'b00, 1'b0, 0, 0);
    end

    @(negedge Clk);
    #1;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
